// File: rtl/ws_core_seq.sv
// Instruction sequencer for the weight-stationary core: weight tile load, activation
// streaming with execute, and concurrent output-FIFO drain into psum SRAM.
module ws_core_seq #(
    parameter int unsigned row     = 8,
    parameter int unsigned col     = 8,
    parameter int unsigned addr_bw = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addr_bw-1:0] cfg_w_base,
    input  logic [addr_bw-1:0] cfg_x_base,
    input  logic [addr_bw-1:0] cfg_n_x,
    input  logic [addr_bw-1:0] cfg_p_base,
    input  logic               ofifo_valid,
    output logic [34:0]        inst,
    output logic               busy,
    output logic               done
);

    localparam int unsigned CntW = addr_bw + 1;

    typedef enum logic [2:0] {
        StIdle,
        StWStream,
        StWSettle,
        StXStream,
        StDrain,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [CntW-1:0]    rd_cnt_q, rd_cnt_d;
    logic [CntW-1:0]    wr_cnt_q, wr_cnt_d;
    logic               wr_pend_q, wr_pend_d;
    logic [addr_bw-1:0] w_base_q, x_base_q, n_x_q, p_base_q;
    logic               accept;

    logic [CntW-1:0]    n_x_ext;
    logic               wb_active;
    logic               ofifo_rd;

    logic               xmem_cen;
    logic               psum_cen;
    logic               psum_wen;
    logic [addr_bw-1:0] xmem_a;
    logic [addr_bw-1:0] psum_a;
    logic               l0_wr;
    logic               l0_rd;
    logic               execute;
    logic               load;

    assign n_x_ext   = {1'b0, n_x_q};
    assign accept    = (state_q == StIdle) && start;
    assign wb_active = (state_q == StXStream) || (state_q == StDrain);
    // Reads are capped at n_x even if the FIFO keeps reporting valid entries.
    assign ofifo_rd  = wb_active && ofifo_valid && (rd_cnt_q < n_x_ext);

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            wr_pend_q <= 1'b0;
            w_base_q  <= '0;
            x_base_q  <= '0;
            n_x_q     <= '0;
            p_base_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            wr_pend_q <= wr_pend_d;
            if (accept) begin
                w_base_q <= cfg_w_base;
                x_base_q <= cfg_x_base;
                n_x_q    <= cfg_n_x;
                p_base_q <= cfg_p_base;
            end
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        rd_cnt_d  = rd_cnt_q + CntW'(ofifo_rd);
        wr_cnt_d  = wr_cnt_q + CntW'(wr_pend_q);
        wr_pend_d = ofifo_rd;

        unique case (state_q)
            StIdle: begin
                cnt_d     = '0;
                rd_cnt_d  = '0;
                wr_cnt_d  = '0;
                wr_pend_d = 1'b0;
                if (start) begin
                    state_d = StWStream;
                end
            end
            StWStream: begin
                if (cnt_q == CntW'(row + 1)) begin
                    state_d = StWSettle;
                    cnt_d   = '0;
                end
            end
            StWSettle: begin
                if (cnt_q == CntW'(col - 1)) begin
                    state_d = (n_x_q != '0) ? StXStream : StDone;
                    cnt_d   = '0;
                end
            end
            StXStream: begin
                if (cnt_q == n_x_ext + 1'b1) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end
            end
            StDrain: begin
                cnt_d = cnt_q;
                // Leave in the cycle that carries the final psum write.
                if (wr_cnt_d == n_x_ext) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Instruction word and status outputs
    always_comb begin
        xmem_cen = 1'b1;
        xmem_a   = '0;
        l0_wr    = 1'b0;
        l0_rd    = 1'b0;
        execute  = 1'b0;
        load     = 1'b0;
        psum_cen = 1'b1;
        psum_wen = 1'b1;
        psum_a   = '0;
        busy     = 1'b0;
        done     = 1'b0;

        unique case (state_q)
            StIdle: begin
            end
            StWStream: begin
                busy = 1'b1;
                if (cnt_q < CntW'(row)) begin
                    xmem_cen = 1'b0;
                    xmem_a   = w_base_q + cnt_q[addr_bw-1:0];
                end
                if ((cnt_q >= CntW'(1)) && (cnt_q <= CntW'(row))) begin
                    l0_wr = 1'b1;
                end
                if (cnt_q >= CntW'(2)) begin
                    l0_rd = 1'b1;
                    load  = 1'b1;
                end
            end
            StWSettle: begin
                busy = 1'b1;
            end
            StXStream: begin
                busy = 1'b1;
                if (cnt_q < n_x_ext) begin
                    xmem_cen = 1'b0;
                    xmem_a   = x_base_q + cnt_q[addr_bw-1:0];
                end
                if ((cnt_q >= CntW'(1)) && (cnt_q <= n_x_ext)) begin
                    l0_wr = 1'b1;
                end
                if (cnt_q >= CntW'(2)) begin
                    l0_rd   = 1'b1;
                    execute = 1'b1;
                end
            end
            StDrain: begin
                busy = 1'b1;
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase

        if (wb_active && wr_pend_q) begin
            psum_cen = 1'b0;
            psum_wen = 1'b0;
            psum_a   = p_base_q + wr_cnt_q[addr_bw-1:0];
        end

        inst = {1'b0, 1'b0, psum_cen, psum_wen, psum_a, xmem_cen, 1'b1, xmem_a,
                ofifo_rd, 2'b00, l0_rd, l0_wr, execute, load};
    end

endmodule
